// File: rtl/cache_scan_fill.sv
// cache_scan_fill
// Scan-port fill/invalidate sequencer sitting in front of the cache controller
// scan port. It takes one whole-line request at a time over valid/ready and
// replays it as a fixed sequence of scan writes:
//   fill       : DAT0..DAT3 (data words), META (clear metadata), TAG, SETTLE, DONE
//   invalidate : INV (clear tags in all ways), SETTLE, DONE
// Every output is a flop. The output values for a cycle are decoded from
// the state being entered, so they line up with state_q.
//
// Ports
//   clk, reset          clock; asynchronous active-low reset
//   req_vld_i/req_rdy_o request handshake (ready only while idle / in DONE)
//   req_inv_i           0 = fill, 1 = invalidate
//   req_addr_i          line address, [8:2] set index, [31:9] tag
//   req_data_i          fill data, word i = [32*i +: 32]
//   req_wayb_i          active-low way enables for fill
//   done_o              one-cycle completion pulse
//   scan_*_o            cache scan port (enable and write enables active-low)
module cache_scan_fill #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_vld_i,
  output logic         req_rdy_o,
  input  logic         req_inv_i,
  input  logic [31:0]  req_addr_i,
  input  logic [127:0] req_data_i,
  input  logic [3:0]   req_wayb_i,
  output logic         done_o,
  output logic         scan_enb_o,
  output logic [8:0]   scan_addr_o,
  output logic [31:0]  scan_data_o,
  output logic [3:0]   scan_web_tag_o,
  output logic [3:0]   scan_web_cache_o,
  output logic         scan_web_meta_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_DAT0, S_DAT1, S_DAT2, S_DAT3, S_META, S_TAG, S_INV, S_SETTLE, S_DONE
  } state_e;

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE_CYCLES - 1);

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [6:0]     lidx_q, lidx_d;
  logic [22:0]    tag_q, tag_d;
  logic [127:0]   data_q, data_d;
  logic [3:0]     wayb_q, wayb_d;

  logic           rdy_q, rdy_d;
  logic           done_q, done_d;
  logic           enb_q, enb_d;
  logic [8:0]     addr_q, addr_d;
  logic [31:0]    sdata_q, sdata_d;
  logic [3:0]     wtag_q, wtag_d;
  logic [3:0]     wcache_q, wcache_d;
  logic           wmeta_q, wmeta_d;

  logic           accept;

  // Word-offset bits of the line address are not used by a whole-line op.
  logic           unused_addr_lsb;
  assign unused_addr_lsb = ^req_addr_i[1:0];

  // rdy_q is only ever set for IDLE/DONE, so it alone qualifies acceptance.
  assign accept = req_vld_i && rdy_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lidx_d   = lidx_q;
    tag_d    = tag_q;
    data_d   = data_q;
    wayb_d   = wayb_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          lidx_d  = req_addr_i[8:2];
          tag_d   = req_addr_i[31:9];
          data_d  = req_data_i;
          wayb_d  = req_wayb_i;
          state_d = req_inv_i ? S_INV : S_DAT0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DAT0:       state_d = S_DAT1;
      S_DAT1:       state_d = S_DAT2;
      S_DAT2:       state_d = S_DAT3;
      S_DAT3:       state_d = S_META;
      S_META:       state_d = S_TAG;
      S_TAG, S_INV: begin
        state_d = S_SETTLE;
        cnt_d   = SETTLE_M1;
      end
      S_SETTLE: begin
        if (cnt_q == 4'd0) state_d = S_DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default:      state_d = S_IDLE;
    endcase
  end

  // Output decode for the state being entered. The *_d capture values equal
  // the request inputs on the accepting edge, so DAT0/INV need no special case.
  always_comb begin
    enb_d    = 1'b1;
    addr_d   = 9'd0;
    sdata_d  = 32'd0;
    wtag_d   = 4'hF;
    wcache_d = 4'hF;
    wmeta_d  = 1'b1;
    done_d   = 1'b0;
    rdy_d    = 1'b0;

    case (state_d)
      S_DAT0: begin
        enb_d = 1'b0; addr_d = {lidx_d, 2'd0}; sdata_d = data_d[31:0];   wcache_d = wayb_d;
      end
      S_DAT1: begin
        enb_d = 1'b0; addr_d = {lidx_d, 2'd1}; sdata_d = data_d[63:32];  wcache_d = wayb_d;
      end
      S_DAT2: begin
        enb_d = 1'b0; addr_d = {lidx_d, 2'd2}; sdata_d = data_d[95:64];  wcache_d = wayb_d;
      end
      S_DAT3: begin
        enb_d = 1'b0; addr_d = {lidx_d, 2'd3}; sdata_d = data_d[127:96]; wcache_d = wayb_d;
      end
      S_META: begin
        enb_d = 1'b0; addr_d = {2'b00, lidx_d}; wmeta_d = 1'b0;
      end
      S_TAG: begin
        // Tag entry: valid bit on top, tag in the low bits.
        enb_d = 1'b0; addr_d = {2'b00, lidx_d}; sdata_d = {1'b1, 8'h00, tag_d}; wtag_d = wayb_d;
      end
      S_INV: begin
        enb_d = 1'b0; addr_d = {2'b00, lidx_d}; wtag_d = 4'h0;
      end
      S_DONE: begin
        done_d = 1'b1; rdy_d = 1'b1;
      end
      S_IDLE:  rdy_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      lidx_q   <= 7'd0;
      tag_q    <= 23'd0;
      data_q   <= 128'd0;
      wayb_q   <= 4'hF;
      rdy_q    <= 1'b0;
      done_q   <= 1'b0;
      enb_q    <= 1'b1;
      addr_q   <= 9'd0;
      sdata_q  <= 32'd0;
      wtag_q   <= 4'hF;
      wcache_q <= 4'hF;
      wmeta_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lidx_q   <= lidx_d;
      tag_q    <= tag_d;
      data_q   <= data_d;
      wayb_q   <= wayb_d;
      rdy_q    <= rdy_d;
      done_q   <= done_d;
      enb_q    <= enb_d;
      addr_q   <= addr_d;
      sdata_q  <= sdata_d;
      wtag_q   <= wtag_d;
      wcache_q <= wcache_d;
      wmeta_q  <= wmeta_d;
    end
  end

  assign req_rdy_o        = rdy_q;
  assign done_o           = done_q;
  assign scan_enb_o       = enb_q;
  assign scan_addr_o      = addr_q;
  assign scan_data_o      = sdata_q;
  assign scan_web_tag_o   = wtag_q;
  assign scan_web_cache_o = wcache_q;
  assign scan_web_meta_o  = wmeta_q;

endmodule

// File: tb/tb_cache_scan_fill.sv
// Bench for cache_scan_fill: a trace model (queue of expected per-cycle
// output snapshots built from the request) checked every cycle, a table of
// directed requests with hand-computed key values, and hand-written
// back-to-back and mid-operation reset sequences, then random requests.
module tb_cache_scan_fill;

  localparam int S = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         req_vld_i = 1'b0;
  logic         req_rdy_o;
  logic         req_inv_i = 1'b0;
  logic [31:0]  req_addr_i = 32'd0;
  logic [127:0] req_data_i = 128'd0;
  logic [3:0]   req_wayb_i = 4'hF;
  logic         done_o;
  logic         scan_enb_o;
  logic [8:0]   scan_addr_o;
  logic [31:0]  scan_data_o;
  logic [3:0]   scan_web_tag_o;
  logic [3:0]   scan_web_cache_o;
  logic         scan_web_meta_o;

  cache_scan_fill #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset),
    .req_vld_i(req_vld_i), .req_rdy_o(req_rdy_o), .req_inv_i(req_inv_i),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_wayb_i(req_wayb_i),
    .done_o(done_o), .scan_enb_o(scan_enb_o), .scan_addr_o(scan_addr_o),
    .scan_data_o(scan_data_o), .scan_web_tag_o(scan_web_tag_o),
    .scan_web_cache_o(scan_web_cache_o), .scan_web_meta_o(scan_web_meta_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        enb;
    logic [8:0]  addr;
    logic [31:0] data;
    logic [3:0]  wtag;
    logic [3:0]  wcache;
    logic        meta;
    logic        done;
    logic        rdy;
  } obs_t;

  localparam obs_t IDLE0 = '{enb:1'b1, addr:9'd0, data:32'd0, wtag:4'hF,
                             wcache:4'hF, meta:1'b1, done:1'b0, rdy:1'b0};

  typedef struct {
    logic         inv;
    logic [31:0]  addr;
    logic [127:0] data;
    logic [3:0]   wayb;
    logic [8:0]   e_addr1;
    logic [31:0]  e_data1;
    logic [3:0]   e_wtag1;
    logic [3:0]   e_wcache1;
    logic [31:0]  e_tagdata;
    int           e_lat;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- trace model ----------------
  obs_t cur = IDLE0;
  obs_t exp_q[$];

  task automatic push_req(input logic inv, input logic [31:0] a,
                          input logic [127:0] d, input logic [3:0] w);
    obs_t o;
    logic [6:0]  l;
    l = a[8:2];
    if (!inv) begin
      for (int i = 0; i < 4; i++) begin
        o = IDLE0; o.enb = 1'b0; o.addr = {l, 2'(i)};
        o.data = d[32*i +: 32]; o.wcache = w;
        exp_q.push_back(o);
      end
      o = IDLE0; o.enb = 1'b0; o.addr = {2'b00, l}; o.meta = 1'b0;
      exp_q.push_back(o);
      o = IDLE0; o.enb = 1'b0; o.addr = {2'b00, l};
      o.data = {1'b1, 8'h00, a[31:9]}; o.wtag = w;
      exp_q.push_back(o);
    end else begin
      o = IDLE0; o.enb = 1'b0; o.addr = {2'b00, l}; o.wtag = 4'h0;
      exp_q.push_back(o);
    end
    for (int i = 0; i < S; i++) exp_q.push_back(IDLE0);
    o = IDLE0; o.done = 1'b1; o.rdy = 1'b1;
    exp_q.push_back(o);
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur = IDLE0;
      exp_q.delete();
    end else begin
      if (cur.rdy && req_vld_i) push_req(req_inv_i, req_addr_i, req_data_i, req_wayb_i);
      if (exp_q.size() > 0) cur = exp_q.pop_front();
      else begin cur = IDLE0; cur.rdy = 1'b1; end
    end
  end

  // ---------------- helpers ----------------
  function automatic obs_t dut_obs();
    return {scan_enb_o, scan_addr_o, scan_data_o, scan_web_tag_o,
            scan_web_cache_o, scan_web_meta_o, done_o, req_rdy_o};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    chk("trace", 64'(dut_obs()), 64'(cur));
  endtask

  task automatic scramble();
    req_inv_i  = 1'($urandom);
    req_addr_i = $urandom;
    req_data_i = {$urandom, $urandom, $urandom, $urandom};
    req_wayb_i = 4'($urandom);
  endtask

  function automatic vec_t mk_vec(input logic inv, input logic [31:0] a,
                                  input logic [127:0] d, input logic [3:0] w);
    vec_t v;
    v.inv = inv; v.addr = a; v.data = d; v.wayb = w;
    v.e_addr1   = inv ? {2'b00, a[8:2]} : {a[8:2], 2'b00};
    v.e_data1   = inv ? 32'd0 : d[31:0];
    v.e_wtag1   = inv ? 4'h0 : 4'hF;
    v.e_wcache1 = inv ? 4'hF : w;
    v.e_tagdata = {1'b1, 8'h00, a[31:9]};
    v.e_lat     = inv ? 2 + S : 7 + S;
    return v;
  endfunction

  task automatic wait_rdy(input string nm);
    int k;
    k = 0;
    while (!req_rdy_o && k < 40) begin tick(); k++; end
    chk({nm, " ready"}, 64'(req_rdy_o), 64'd1);
  endtask

  // Issue one request, scramble inputs while busy, record key cycles.
  task automatic do_req(input vec_t v, input string nm);
    logic [8:0]  r_addr [1:48];
    logic [31:0] r_data [1:48];
    logic [3:0]  r_wtag [1:48];
    logic [3:0]  r_wc   [1:48];
    int lat;
    wait_rdy(nm);
    req_vld_i = 1'b1; req_inv_i = v.inv; req_addr_i = v.addr;
    req_data_i = v.data; req_wayb_i = v.wayb;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 1) req_vld_i = 1'b0;
      r_addr[c] = scan_addr_o; r_data[c] = scan_data_o;
      r_wtag[c] = scan_web_tag_o; r_wc[c] = scan_web_cache_o;
      if (done_o) begin lat = c; break; end
      scramble();
    end
    chk({nm, " done latency"}, 64'(lat), 64'(v.e_lat));
    chk({nm, " addr1"}, 64'(r_addr[1]), 64'(v.e_addr1));
    chk({nm, " data1"}, 64'(r_data[1]), 64'(v.e_data1));
    chk({nm, " wtag1"}, 64'(r_wtag[1]), 64'(v.e_wtag1));
    chk({nm, " wcache1"}, 64'(r_wc[1]), 64'(v.e_wcache1));
    if (!v.inv) chk({nm, " tag data"}, 64'(r_data[6]), 64'(v.e_tagdata));
  endtask

  // ---------------- test ----------------
  vec_t tbl[5];
  int   lat;

  initial begin
    tbl[0] = '{inv:1'b0, addr:32'h0000_1A4C,
               data:{32'hA3, 32'hA2, 32'hA1, 32'hA0}, wayb:4'b1110,
               e_addr1:9'h04C, e_data1:32'hA0, e_wtag1:4'hF, e_wcache1:4'b1110,
               e_tagdata:32'h8000_000D, e_lat:9};
    tbl[1] = '{inv:1'b1, addr:32'h0000_01FC, data:128'd0, wayb:4'hF,
               e_addr1:9'h07F, e_data1:32'd0, e_wtag1:4'h0, e_wcache1:4'hF,
               e_tagdata:32'd0, e_lat:4};
    tbl[2] = '{inv:1'b0, addr:32'hFFFF_FFFC,
               data:{32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF},
               wayb:4'hF, e_addr1:9'h1FC, e_data1:32'hDEAD_BEEF, e_wtag1:4'hF,
               e_wcache1:4'hF, e_tagdata:32'h807F_FFFF, e_lat:9};
    tbl[3] = '{inv:1'b0, addr:32'h0000_0200,
               data:{32'h0, 32'h0, 32'h0, 32'h1111_1111}, wayb:4'b0101,
               e_addr1:9'h000, e_data1:32'h1111_1111, e_wtag1:4'hF,
               e_wcache1:4'b0101, e_tagdata:32'h8000_0001, e_lat:9};
    tbl[4] = '{inv:1'b1, addr:32'h1234_5678, data:128'd0, wayb:4'h0,
               e_addr1:9'h01E, e_data1:32'd0, e_wtag1:4'h0, e_wcache1:4'hF,
               e_tagdata:32'd0, e_lat:4};

    // Reset held for 3 cycles.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset enb", 64'(scan_enb_o), 64'd1);
    end
    reset = 1'b1;
    tick();
    chk("rdy after reset", 64'(req_rdy_o), 64'd1);

    // Directed table.
    for (int i = 0; i < 5; i++) do_req(tbl[i], $sformatf("vec%0d", i));

    // Back-to-back: fill then invalidate with valid held high.
    wait_rdy("b2b");
    req_vld_i = 1'b1; req_inv_i = 1'b0; req_addr_i = 32'h0000_1A4C;
    req_data_i = {32'h13, 32'h12, 32'h11, 32'h10}; req_wayb_i = 4'b0011;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 1) begin req_inv_i = 1'b1; req_addr_i = 32'h0000_0154; req_wayb_i = 4'h0; end
      if (done_o) begin lat = c; break; end
    end
    chk("b2b fill latency", 64'(lat), 64'(7 + S));
    tick();
    req_vld_i = 1'b0;
    chk("b2b inv enb", 64'(scan_enb_o), 64'd0);
    chk("b2b inv addr", 64'(scan_addr_o), 64'h055);
    chk("b2b inv wtag", 64'(scan_web_tag_o), 64'h0);
    for (int c = 0; c < 40 && !done_o; c++) tick();
    chk("b2b inv done", 64'(done_o), 64'd1);

    // Reset mid-fill, during DAT2.
    wait_rdy("midrst");
    req_vld_i = 1'b1; req_inv_i = 1'b0; req_addr_i = 32'h0000_0A08;
    req_data_i = {4{32'h5A5A_0000}}; req_wayb_i = 4'b1000;
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 1) req_vld_i = 1'b0;
    end
    chk("midrst in DAT2 enb", 64'(scan_enb_o), 64'd0);
    #2 reset = 1'b0;
    #1 chk("midrst async idle", 64'(dut_obs()), 64'(IDLE0));
    tick();
    reset = 1'b1;
    tick();
    chk("midrst rdy after release", 64'(req_rdy_o), 64'd1);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("midrst no done", 64'(done_o), 64'd0);
    end
    do_req(mk_vec(1'b0, 32'h0000_0A08, {32'h4, 32'h3, 32'h2, 32'h1}, 4'b0110), "post-rst fill");

    // Random requests with random gaps.
    for (int n = 0; n < 30; n++) begin
      logic ri;
      logic [3:0] rw;
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) tick();
      ri = ($urandom_range(0, 2) == 0);
      rw = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom);
      do_req(mk_vec(ri, $urandom, {$urandom, $urandom, $urandom, $urandom}, rw),
             $sformatf("rnd%0d", n));
    end
    for (int c = 0; c < 4; c++) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
